// File: rtl/wb_stage_reg.sv
// wb_stage_reg: MEM/WB pipeline register with load extraction, write-back mux and optional retired-instruction counter.
// Define WB_INSTRET_EN to build the instret counter; otherwise instret_out is tied to 0.
module wb_stage_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  mem_valid_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       read_data_in,
    input  logic [XLEN-1:0]       pc_plus_4_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            wb_sel_in,
    input  logic [2:0]            load_funct3_in,
    output logic [XLEN-1:0]       wb_write_data_out,
    output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
    output logic                  wb_reg_write_en_out,
    output logic                  wb_valid_out,
    output logic [CNT_W-1:0]      instret_out
);
    logic [31:0]     ld_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wb_data;
    logic            capture;
    logic            unused_ok;

    assign unused_ok = ^{alu_result_in, read_data_in};

    always_comb begin
        ld_word = read_data_in[31:0];
        ld_byte = 8'(ld_word >> {alu_result_in[1:0], 3'b000});
        ld_half = alu_result_in[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = load_funct3_in == 3'b000 ? XLEN'($signed(ld_byte)) :
                  load_funct3_in == 3'b001 ? XLEN'($signed(ld_half)) :
                  load_funct3_in == 3'b100 ? XLEN'(ld_byte) :
                  load_funct3_in == 3'b101 ? XLEN'(ld_half) :
                                             XLEN'($signed(ld_word));
        wb_data = wb_sel_in == 2'b01 ? ld_data :
                  wb_sel_in == 2'b10 ? pc_plus_4_in : alu_result_in;
    end

    assign capture = !flush_in && !stall_in;

    always_ff @(posedge clk) begin
        if (rst || flush_in) begin
            wb_write_data_out   <= '0;
            wb_rd_addr_out      <= '0;
            wb_reg_write_en_out <= 1'b0;
            wb_valid_out        <= 1'b0;
        end else if (capture) begin
            wb_write_data_out   <= wb_data;
            wb_rd_addr_out      <= rd_addr_in;
            wb_reg_write_en_out <= mem_valid_in && reg_write_in && (rd_addr_in != '0);
            wb_valid_out        <= mem_valid_in;
        end
    end

`ifdef WB_INSTRET_EN
    // Counts on the same edge as the capture so it never lags wb_valid_out.
    always_ff @(posedge clk) begin
        if (rst)
            instret_out <= '0;
        else if (capture && mem_valid_in)
            instret_out <= instret_out + 1'b1;
    end
`else
    assign instret_out = '0;
`endif
endmodule

// File: tb/tb_wb_stage_reg.sv
// tb_wb_stage_reg: table-driven directed checks of wb_stage_reg, plus a CNT_W=4 instance for counter wrap.
module tb_wb_stage_reg;
    logic        clk = 0;
    logic        rst, stall_in, flush_in, mem_valid_in, reg_write_in;
    logic [31:0] alu_result_in, read_data_in, pc_plus_4_in;
    logic [4:0]  rd_addr_in;
    logic [1:0]  wb_sel_in;
    logic [2:0]  load_funct3_in;
    logic [31:0] wb_write_data_out, w4_data;
    logic [4:0]  wb_rd_addr_out, w4_addr;
    logic        wb_reg_write_en_out, wb_valid_out, w4_en, w4_vld;
    logic [63:0] instret_out;
    logic [3:0]  instret4;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    wb_stage_reg dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .mem_valid_in(mem_valid_in), .alu_result_in(alu_result_in),
        .read_data_in(read_data_in), .pc_plus_4_in(pc_plus_4_in),
        .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
        .wb_sel_in(wb_sel_in), .load_funct3_in(load_funct3_in),
        .wb_write_data_out(wb_write_data_out), .wb_rd_addr_out(wb_rd_addr_out),
        .wb_reg_write_en_out(wb_reg_write_en_out), .wb_valid_out(wb_valid_out),
        .instret_out(instret_out)
    );

    wb_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .mem_valid_in(mem_valid_in), .alu_result_in(alu_result_in),
        .read_data_in(read_data_in), .pc_plus_4_in(pc_plus_4_in),
        .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
        .wb_sel_in(wb_sel_in), .load_funct3_in(load_funct3_in),
        .wb_write_data_out(w4_data), .wb_rd_addr_out(w4_addr),
        .wb_reg_write_en_out(w4_en), .wb_valid_out(w4_vld),
        .instret_out(instret4)
    );

    typedef struct {
        logic        stall, flush, valid, rw;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu, rdat, pc4;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic        e_en, e_vld;
        int          e_cnt;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(logic st, logic fl, logic v, logic rw, logic [1:0] sel, logic [2:0] f3,
                                logic [4:0] rd, logic [31:0] alu, logic [31:0] rdat, logic [31:0] pc4,
                                logic [31:0] ed, logic [4:0] ea, logic ee, logic ev, int ec);
        vec_t r;
        r.stall = st; r.flush = fl; r.valid = v; r.rw = rw; r.sel = sel; r.f3 = f3; r.rd = rd;
        r.alu = alu; r.rdat = rdat; r.pc4 = pc4;
        r.e_data = ed; r.e_addr = ea; r.e_en = ee; r.e_vld = ev; r.e_cnt = ec;
        return r;
    endfunction

    function automatic logic [63:0] exp_cnt(int c);
`ifdef WB_INSTRET_EN
        return 64'(c);
`else
        return 64'(c - c);
`endif
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [31:0] d, logic [4:0] a, logic e, logic v, int c);
        chk({tag, " data"}, 64'(wb_write_data_out), 64'(d));
        chk({tag, " addr"}, 64'(wb_rd_addr_out), 64'(a));
        chk({tag, " en"}, 64'(wb_reg_write_en_out), 64'(e));
        chk({tag, " valid"}, 64'(wb_valid_out), 64'(v));
        chk({tag, " instret"}, instret_out, exp_cnt(c));
        chk({tag, " instret4"}, 64'(instret4), exp_cnt(c) & 64'hF);
    endtask

    task automatic drive(vec_t t);
        stall_in = t.stall; flush_in = t.flush; mem_valid_in = t.valid; reg_write_in = t.rw;
        wb_sel_in = t.sel; load_funct3_in = t.f3; rd_addr_in = t.rd;
        alu_result_in = t.alu; read_data_in = t.rdat; pc_plus_4_in = t.pc4;
    endtask

    initial begin
        tv[0]  = mk(0,0,1,1,2'b00,3'b000,5'd1,32'h11,0,0,               32'h11,5'd1,1,1,1);
        tv[1]  = mk(0,0,1,1,2'b00,3'b000,5'd2,32'h22,0,0,               32'h22,5'd2,1,1,2);
        tv[2]  = mk(0,0,1,1,2'b00,3'b000,5'd3,32'h33,0,0,               32'h33,5'd3,1,1,3);
        tv[3]  = mk(0,0,1,1,2'b01,3'b000,5'd4,32'h3,32'h80FF7F01,0,     32'hFFFFFF80,5'd4,1,1,4);
        tv[4]  = mk(0,0,1,1,2'b01,3'b100,5'd4,32'h3,32'h80FF7F01,0,     32'h00000080,5'd4,1,1,5);
        tv[5]  = mk(0,0,1,1,2'b01,3'b001,5'd4,32'h2,32'h80FF7F01,0,     32'hFFFF80FF,5'd4,1,1,6);
        tv[6]  = mk(0,0,1,1,2'b01,3'b101,5'd4,32'h3,32'h80FF7F01,0,     32'h000080FF,5'd4,1,1,7);
        tv[7]  = mk(0,0,1,1,2'b01,3'b010,5'd4,32'h0,32'h80FF7F01,0,     32'h80FF7F01,5'd4,1,1,8);
        tv[8]  = mk(0,0,1,1,2'b01,3'b011,5'd4,32'h1,32'h80FF7F01,0,     32'h80FF7F01,5'd4,1,1,9);
        tv[9]  = mk(0,0,1,1,2'b01,3'b000,5'd4,32'h1,32'h80FF7F01,0,     32'h0000007F,5'd4,1,1,10);
        tv[10] = mk(0,0,1,1,2'b10,3'b000,5'd1,32'h55,0,32'h1004,        32'h1004,5'd1,1,1,11);
        tv[11] = mk(0,0,1,1,2'b10,3'b000,5'd0,32'h55,0,32'h1004,        32'h1004,5'd0,0,1,12);
        tv[12] = mk(0,0,1,1,2'b11,3'b000,5'd6,32'h77,0,32'h1004,        32'h77,5'd6,1,1,13);
        tv[13] = mk(0,0,1,1,2'b00,3'b000,5'd5,32'hAB,0,0,               32'hAB,5'd5,1,1,14);
        tv[14] = mk(1,0,1,1,2'b00,3'b000,5'd7,32'h99,0,0,               32'hAB,5'd5,1,1,14);
        tv[15] = mk(1,0,1,1,2'b10,3'b000,5'd8,32'h98,0,32'h2000,        32'hAB,5'd5,1,1,14);
        tv[16] = mk(1,1,1,1,2'b00,3'b000,5'd7,32'h99,0,0,               32'h0,5'd0,0,0,14);
        tv[17] = mk(0,0,0,1,2'b00,3'b000,5'd8,32'h44,0,0,               32'h44,5'd8,0,0,14);
        tv[18] = mk(0,0,1,1,2'b00,3'b000,5'd0,32'h66,0,0,               32'h66,5'd0,0,1,15);
        tv[19] = mk(0,1,1,1,2'b00,3'b000,5'd9,32'h67,0,0,               32'h0,5'd0,0,0,15);
        tv[20] = mk(0,0,1,1,2'b00,3'b000,5'd9,32'h12,0,0,               32'h12,5'd9,1,1,16);
        tv[21] = mk(0,0,1,1,2'b00,3'b000,5'd10,32'h13,0,0,              32'h13,5'd10,1,1,17);

        rst = 1;
        drive(mk(0,0,1,1,2'b00,3'b000,5'd3,32'hDEAD,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 32'h0, 5'd0, 0, 0, 0);
        rst = 0;
        drive(mk(0,0,0,0,2'b00,3'b000,5'd0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            drive(tv[i]);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), tv[i].e_data, tv[i].e_addr, tv[i].e_en, tv[i].e_vld, tv[i].e_cnt);
        end

        // reset asserted while stalled clears everything on that edge
        drive(mk(1,0,1,1,2'b00,3'b000,5'd11,32'h5,0,0,0,0,0,0,0));
        rst = 1;
        @(posedge clk);
        #1 chk_all("rst_in_stall", 32'h0, 5'd0, 0, 0, 0);
        rst = 0;
        stall_in = 0;
        @(posedge clk);
        #1 chk_all("first_after_rst", 32'h5, 5'd11, 1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
